// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the write port of the dual-clock
// FIFO among NUM_REQ valid/ready requesters in the write clock domain. A grant
// is held for a whole packet, capped at MAX_BURST beats, and no write is ever
// issued while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   last_grant_nxt;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   idx;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  beat_cnt_nxt;
  logic              found;
  logic              sel_valid;
  logic              sel_last;
  logic              transfer;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotating-priority search: first valid requester after the last one granted.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Select the granted requester's valid, last and data lanes.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic and combinational handshake/write outputs.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    req_ready      = '0;
    transfer       = 1'b0;
    fifo_wr_en     = 1'b0;
    busy           = 1'b0;
    fifo_data      = sel_data;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          grant_nxt    = winner;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == ID_W'(i)) begin
            req_ready[i] = !fifo_full;
          end
        end
        transfer   = sel_valid && !fifo_full;
        fifo_wr_en = transfer;
        if (transfer) begin
          if (sel_last || (beat_cnt == CNT_MAX)) begin
            last_grant_nxt = grant_id;
            state_nxt      = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter. Requester drivers
// feed packets from per-requester beat queues; a transaction-level reference
// model (rotating priority list, owner and beat count) predicts each cycle's
// handshake and FIFO write, and a negedge monitor compares the DUT to it.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
  } wr_t;

  typedef struct packed {
    logic               busy;
    logic [NUM_REQ-1:0] ready;
    logic               wr;
  } st_t;

  logic                     clk_wr;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*DW-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [DW-1:0]            fifo_data;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  int  tests;
  int  fails;
  logic mon_en;

  logic [DW:0] beat_q [NUM_REQ][$];
  wr_t exp_wr[$];
  st_t exp_st[$];

  int owner;
  int beats;
  int prio[$];

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_wr    (clk_wr),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Free-running write clock.
  initial begin
    clk_wr = 1'b0;
    forever #5 clk_wr = ~clk_wr;
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    owner = -1;
    beats = 0;
    prio.delete();
    for (int i = 0; i < NUM_REQ; i++) prio.push_back(i);
  endfunction

  task automatic add_packet(input int r, input int len);
    logic [DW:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1) ? 1'b1 : 1'b0, DW'($urandom)};
      beat_q[r].push_back(b);
    end
  endtask

  // Drive one cycle of requester/FIFO inputs, predict the response, advance one clock.
  task automatic applyStimulus(input int pv, input int pf, input logic [NUM_REQ-1:0] en);
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ-1:0]    l;
    logic [NUM_REQ*DW-1:0] d;
    logic                  f;
    logic [DW:0]           b;
    st_t                   st;
    wr_t                   wr;
    int                    xfer_id;
    xfer_id = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0;
      l[i] = 1'($urandom_range(1));
      d[i*DW +: DW] = DW'($urandom);
      if (en[i] && beat_q[i].size() > 0 && int'($urandom_range(99)) < pv) begin
        b = beat_q[i][0];
        v[i] = 1'b1;
        l[i] = b[DW];
        d[i*DW +: DW] = b[DW-1:0];
      end
    end
    f = (int'($urandom_range(99)) < pf);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_full = f;

    st = '0;
    if (owner < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (owner < 0 && v[prio[k]]) begin
          owner = prio[k];
          beats = 0;
        end
      end
    end else begin
      st.busy = 1'b1;
      if (!f) st.ready[owner] = 1'b1;
      if (v[owner] && !f) begin
        st.wr   = 1'b1;
        wr.id   = ID_W'(owner);
        wr.data = d[owner*DW +: DW];
        exp_wr.push_back(wr);
        xfer_id = owner;
        beats++;
        if (l[owner] || beats == MAX_BURST) begin
          while (prio[$] != owner) prio.push_back(prio.pop_front());
          owner = -1;
        end
      end
    end
    exp_st.push_back(st);
    if (xfer_id >= 0) void'(beat_q[xfer_id].pop_front());
    @(posedge clk_wr);
    #1;
  endtask

  // Compare the DUT's handshake and any FIFO write against the scoreboard.
  task automatic checkOutput();
    st_t st;
    wr_t wr;
    if (exp_st.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL status_underflow: got no prediction, required one at %0t", $time);
    end else begin
      st = exp_st.pop_front();
      checkValue("status{busy,ready,wr}", 32'({busy, req_ready, fifo_wr_en}), 32'(st));
    end
    if (fifo_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got data 0x%0h, required no write at %0t", fifo_data, $time);
      end else begin
        wr = exp_wr.pop_front();
        checkValue("write{grant_id,data}", 32'({grant_id, fifo_data}), 32'(wr));
      end
    end
  endtask

  // Monitor: sample DUT outputs mid-cycle, away from the active edge.
  always @(negedge clk_wr) begin
    if (mon_en) checkOutput();
  end

  function automatic bit pending();
    bit p;
    p = (owner >= 0);
    for (int i = 0; i < NUM_REQ; i++) if (beat_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain();
    int budget;
    budget = 0;
    while (pending() && budget < 300) begin
      applyStimulus(100, 0, '1);
      budget++;
    end
    tests++;
    if (budget >= 300) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d cycles, required under 300", budget);
    end
  endtask

  initial begin
    logic [DW:0] b;
    tests     = 0;
    fails     = 0;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();

    #2;
    checkValue("reset_busy", 32'(busy), 32'd0);
    checkValue("reset_ready", 32'(req_ready), 32'd0);
    checkValue("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkValue("reset_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk_wr);
    rst_n = 1'b1;
    @(posedge clk_wr);
    #1;
    mon_en = 1'b1;

    // Single requester, three beats.
    beat_q[2].push_back({1'b0, 8'hA1});
    beat_q[2].push_back({1'b0, 8'hA2});
    beat_q[2].push_back({1'b1, 8'hA3});
    for (int c = 0; c < 6; c++) applyStimulus(100, 0, '1);

    // Fairness: every requester holds single-beat packets.
    for (int i = 0; i < NUM_REQ; i++) for (int p = 0; p < 4; p++) add_packet(i, 1);
    drain();

    // Burst cap: six-beat packet competing with another requester.
    add_packet(1, 6);
    add_packet(3, 2);
    drain();

    // Backpressure: full for five cycles after the second beat.
    add_packet(0, 4);
    for (int c = 0; c < 3; c++) applyStimulus(100, 0, '1);
    for (int c = 0; c < 5; c++) applyStimulus(100, 100, '1);
    drain();

    // Valid gap on the granted requester while another waits.
    add_packet(1, 4);
    add_packet(2, 2);
    for (int c = 0; c < 3; c++) applyStimulus(100, 0, 4'b0010);
    for (int c = 0; c < 3; c++) applyStimulus(100, 0, 4'b0100);
    drain();

    // Randomized traffic with backpressure and valid gaps.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (beat_q[i].size() == 0 && $urandom_range(99) < 30) add_packet(i, int'($urandom_range(1, 6)));
      end
      applyStimulus(75, 20, '1);
    end
    drain();

    // Reset while requester 0 presents its second beat.
    add_packet(0, 4);
    applyStimulus(100, 0, 4'b0001);
    applyStimulus(100, 0, 4'b0001);
    mon_en = 1'b0;
    b = beat_q[0][0];
    req_valid = 4'b0001;
    req_last  = {3'b000, b[DW]};
    req_data  = {{(NUM_REQ-1)*DW{1'b0}}, b[DW-1:0]};
    fifo_full = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkValue("midreset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkValue("midreset_busy", 32'(busy), 32'd0);
    checkValue("midreset_ready", 32'(req_ready), 32'd0);
    checkValue("midreset_grant_id", 32'(grant_id), 32'd0);
    req_valid = '0;
    exp_st.delete();
    exp_wr.delete();
    beat_q[0].delete();
    model_reset();
    @(negedge clk_wr);
    rst_n = 1'b1;
    @(posedge clk_wr);
    #1;
    mon_en = 1'b1;
    add_packet(2, 1);
    add_packet(3, 1);
    drain();

    mon_en = 1'b0;
    tests++;
    if (exp_st.size() != 0 || exp_wr.size() != 0) begin
      fails++;
      $display("[TB] FAIL leftover_predictions: got %0d status/%0d writes pending, required 0/0",
               exp_st.size(), exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the dual-clock FIFO among NUM_REQ requesters in the write clock domain. Each requester presents a valid/ready stream with packet delimiters. The arbiter grants one requester at a time and holds the grant for a whole packet, capped at MAX_BURST beats. It drives the FIFO's wr_en/data_in and never writes while the FIFO reports full.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, FIFO data width
- MAX_BURST, 4, max beats per grant before forced rotation (power of two, >=1)
- clk_wr  in  1  write-domain clock, posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet (qualified by valid)
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle
- fifo_full  in  1  FIFO full flag (clk_wr domain)
- fifo_wr_en  out  1  FIFO write enable
- fifo_data  out  DATA_WIDTH  FIFO write data
- grant_id  out  clog2(NUM_REQ)  currently/last granted requester
- busy  out  1  high while in GRANT

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, last_grant, beat_cnt (clog2(MAX_BURST) bits, min 1).
- IDLE: if any req_valid, winner = first i with req_valid[i], searching (last_grant+1) mod NUM_REQ upward with wrap. grant_id <= winner, beat_cnt <= 0, state <= GRANT. Otherwise stay in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits = 0.
  - Transfer = req_valid[grant_id] && req_ready[grant_id].
  - fifo_wr_en = transfer. fifo_data = req_data slice of grant_id. Both are combinational.
  - On transfer with req_last[grant_id] or beat_cnt == MAX_BURST-1: last_grant <= grant_id, state <= IDLE.
  - On any other transfer: beat_cnt <= beat_cnt+1.
- Requester drops valid mid-packet: grant held, beat_cnt unchanged, no write.
- fifo_full high: no transfer, grant held. A requester never sees ready while full.
- Burst cap forces rotation mid-packet. The requester re-arbitrates for the remainder. Packet integrity in the FIFO is not guaranteed across a cap; callers needing it set MAX_BURST >= max packet length.
- In IDLE, req_ready = 0 and fifo_wr_en = 0.
- fifo_data in IDLE: drives req_data slice of grant_id. It is don't-care.

## Timing
- Reset values: state IDLE, grant_id 0, last_grant NUM_REQ-1 (requester 0 wins first), beat_cnt 0, busy 0, req_ready 0, fifo_wr_en 0.
- Arbitration costs one cycle. A valid seen at edge n in IDLE gives GRANT from edge n+1, and the first beat can transfer in that same cycle.
- Write latency requester->FIFO: 0 cycles. The FIFO samples fifo_wr_en/fifo_data at the same clk_wr edge that completes the handshake.
- Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles. Single-beat packets give 1 beat per 2 cycles.
- Simultaneous requests resolve purely by rotating priority, and no requester waits more than NUM_REQ-1 grants.
- A new request arriving while another requester is in GRANT is not considered until the return to IDLE.
- rst_n asserted mid-GRANT: all state returns to reset values immediately (async). Any partial packet is abandoned and no further write is issued.

## Test plan
- Reset then single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd), FIFO not full -> GRANT 1 cycle after valid, fifo_wr_en high 3 consecutive cycles with those data, grant_id=2, then IDLE.
- Fairness: all 4 requesters hold single-beat packets continuously after reset -> grant order 0,1,2,3,0,1…, one write every 2 cycles.
- Burst cap: MAX_BURST=4, req 1 sends 6-beat packet while req 3 also valid -> 4 beats from req 1, then req 3's packet, then remaining 2 beats from req 1.
- Backpressure: fifo_full asserted after 2nd beat of 4-beat packet for 5 cycles -> req_ready and fifo_wr_en low those 5 cycles, beats 3–4 written after full drops, no data lost or duplicated.
- Valid gap: granted requester deasserts valid for 3 cycles mid-packet while another requester is valid -> grant held, no writes during gap, packet completes before the other is granted.
- Reset mid-packet: rst_n pulsed low during beat 2 of req 0 -> fifo_wr_en 0 immediately, busy 0, next grant goes to the lowest-index valid requester.
